// File: rtl/register_file_scoreboard.sv
// CPU register file with two bypassed read ports, one write port, and a per-register busy
// scoreboard that lets decode detect RAW hazards on writes still in flight.
module register_file_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic              Issue,
    input  logic [ADDR_W-1:0] IssueReg,
    output logic [ADDR_W:0]   PendingCount,
    input  logic [ADDR_W-1:0] RegFile_Address,
    output logic [DATA_W-1:0] RegOutOutOut
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [ADDR_W:0]     r_pending;

    logic                w_wr_en;
    logic                w_rd1_zero;
    logic                w_rd2_zero;
    logic                w_rd1_hit;
    logic                w_rd2_hit;
    logic [NUM_REGS-1:0] w_busy_next;
    logic [ADDR_W:0]     w_busy_cnt;

    // Writes to the hardwired zero register are dropped entirely, including for bypass.
    assign w_wr_en    = RegWrite && !(ZERO_REG && (WriteReg == '0));
    assign w_rd1_zero = ZERO_REG && (ReadReg1 == '0);
    assign w_rd2_zero = ZERO_REG && (ReadReg2 == '0);
    assign w_rd1_hit  = w_wr_en && (WriteReg == ReadReg1);
    assign w_rd2_hit  = w_wr_en && (WriteReg == ReadReg2);

    assign ReadData1 = w_rd1_zero ? '0 : (w_rd1_hit ? WriteData : r_regs[ReadReg1]);
    assign ReadData2 = w_rd2_zero ? '0 : (w_rd2_hit ? WriteData : r_regs[ReadReg2]);

    assign Busy1 = r_busy[ReadReg1] && !(RegWrite && (WriteReg == ReadReg1));
    assign Busy2 = r_busy[ReadReg2] && !(RegWrite && (WriteReg == ReadReg2));

    assign RegOutOutOut = r_regs[RegFile_Address];
    assign PendingCount = r_pending;

    // Issue wins over a same-cycle writeback clear so a re-issued destination stays tracked.
    always_comb begin
        w_busy_next = r_busy;
        w_busy_cnt  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (Issue && (IssueReg == ADDR_W'(i))) begin
                w_busy_next[i] = 1'b1;
            end else if (RegWrite && (WriteReg == ADDR_W'(i))) begin
                w_busy_next[i] = 1'b0;
            end
            if (ZERO_REG && (i == 0)) begin
                w_busy_next[i] = 1'b0;
            end
            w_busy_cnt = w_busy_cnt + (ADDR_W + 1)'(w_busy_next[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy    <= '0;
            r_pending <= '0;
        end else begin
            if (w_wr_en) begin
                r_regs[WriteReg] <= WriteData;
            end
            r_busy    <= w_busy_next;
            r_pending <= w_busy_cnt;
        end
    end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed bench for register_file_scoreboard: a behavioural register/busy model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_register_file_scoreboard;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    logic              clock;
    logic              reset;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              Busy1;
    logic              Busy2;
    logic              Issue;
    logic [ADDR_W-1:0] IssueReg;
    logic [ADDR_W:0]   PendingCount;
    logic [ADDR_W-1:0] RegFile_Address;
    logic [DATA_W-1:0] RegOutOutOut;

    int n_compared;
    int n_failed;
    bit check_en;

    logic [DATA_W-1:0] mdl_regs [NUM_REGS];
    bit                mdl_busy [NUM_REGS];

    register_file_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1)) dut (
        .clock(clock), .reset(reset),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .Busy1(Busy1), .Busy2(Busy2),
        .Issue(Issue), .IssueReg(IssueReg),
        .PendingCount(PendingCount),
        .RegFile_Address(RegFile_Address), .RegOutOutOut(RegOutOutOut)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: state changes applied at the clock edge from the inputs that were held during the cycle.
    initial begin
        for (int i = 0; i < NUM_REGS; i++) begin
            mdl_regs[i] = '0;
            mdl_busy[i] = 1'b0;
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mdl_regs[i] = '0;
                mdl_busy[i] = 1'b0;
            end
        end else begin
            if (RegWrite) begin
                if (WriteReg != 0) mdl_regs[WriteReg] = WriteData;
                mdl_busy[WriteReg] = 1'b0;
            end
            if (Issue && IssueReg != 0) mdl_busy[IssueReg] = 1'b1;
        end
    end

    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] idx);
        if (idx == 0) return '0;
        if (RegWrite && WriteReg == idx) return WriteData;
        return mdl_regs[idx];
    endfunction

    function automatic logic exp_busy(input logic [ADDR_W-1:0] idx);
        return mdl_busy[idx] && !(RegWrite && WriteReg == idx);
    endfunction

    function automatic int exp_pending();
        int n = 0;
        foreach (mdl_busy[i]) n += int'(mdl_busy[i]);
        return n;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (check_en) begin
            check("m_rd1",  ReadData1, exp_read(ReadReg1));
            check("m_rd2",  ReadData2, exp_read(ReadReg2));
            check("m_busy1", DATA_W'(Busy1), DATA_W'(exp_busy(ReadReg1)));
            check("m_busy2", DATA_W'(Busy2), DATA_W'(exp_busy(ReadReg2)));
            check("m_pend", DATA_W'(PendingCount), DATA_W'(exp_pending()));
            check("m_dbg",  RegOutOutOut, mdl_regs[RegFile_Address]);
        end
    end

    // driver tasks
    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
        Issue = 1'b0; IssueReg = '0;
    endtask

    initial begin
        n_compared = 0;
        n_failed   = 0;
        check_en   = 1'b0;
        reset = 1'b1;
        idle_inputs();
        ReadReg1 = '0; ReadReg2 = '0; RegFile_Address = '0;
        advance();
        check_en = 1'b1;
        advance();
        reset = 1'b0;

        // Cleared state visible on every index of both ports.
        for (int i = 0; i < NUM_REGS; i++) begin
            ReadReg1 = ADDR_W'(i);
            ReadReg2 = ADDR_W'(NUM_REGS - 1 - i);
            RegFile_Address = ADDR_W'(i);
            settle();
            check("rst_rd1", ReadData1, 32'h0);
            check("rst_rd2", ReadData2, 32'h0);
            check("rst_busy", DATA_W'({Busy1, Busy2}), 32'h0);
            check("rst_pend", DATA_W'(PendingCount), 32'h0);
            advance();
        end

        // Same-cycle bypass, then stored value and debug port.
        RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEADBEEF;
        ReadReg1 = 5'd5; RegFile_Address = 5'd5;
        settle();
        check("byp_rd1", ReadData1, 32'hDEADBEEF);
        check("byp_dbg_nobypass", RegOutOutOut, 32'h0);
        advance();
        idle_inputs();
        settle();
        check("stored_rd1", ReadData1, 32'hDEADBEEF);
        check("stored_dbg", RegOutOutOut, 32'hDEADBEEF);
        advance();

        // Register 0: write and issue both ignored.
        RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h1234;
        Issue = 1'b1; IssueReg = 5'd0; ReadReg1 = 5'd0; RegFile_Address = 5'd0;
        settle();
        check("z_rd1_same", ReadData1, 32'h0);
        advance();
        idle_inputs();
        settle();
        check("z_rd1", ReadData1, 32'h0);
        check("z_busy1", DATA_W'(Busy1), 32'h0);
        check("z_pend", DATA_W'(PendingCount), 32'h0);
        check("z_dbg", RegOutOutOut, 32'h0);
        advance();

        // Issue then writeback clears the hazard combinationally.
        Issue = 1'b1; IssueReg = 5'd7; ReadReg2 = 5'd7;
        settle();
        check("i7_busy2_before", DATA_W'(Busy2), 32'h0);
        advance();
        idle_inputs();
        settle();
        check("i7_busy2", DATA_W'(Busy2), 32'h1);
        check("i7_pend", DATA_W'(PendingCount), 32'h1);
        advance();
        RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'd42;
        settle();
        check("w7_busy2", DATA_W'(Busy2), 32'h0);
        check("w7_rd2", ReadData2, 32'd42);
        check("w7_pend_lag", DATA_W'(PendingCount), 32'h1);
        advance();
        idle_inputs();
        settle();
        check("w7_pend", DATA_W'(PendingCount), 32'h0);
        check("w7_rd2_stored", ReadData2, 32'd42);
        advance();

        // Issue and writeback on the same busy register: data lands, busy stays.
        Issue = 1'b1; IssueReg = 5'd3;
        advance();
        RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'd9; ReadReg1 = 5'd3;
        settle();
        check("r3_rd1_byp", ReadData1, 32'd9);
        advance();
        idle_inputs();
        settle();
        check("r3_rd1", ReadData1, 32'd9);
        check("r3_busy1", DATA_W'(Busy1), 32'h1);
        check("r3_pend", DATA_W'(PendingCount), 32'h1);
        advance();

        // Issue 10 while writing 3: both effects in one cycle; then WAW on 10.
        Issue = 1'b1; IssueReg = 5'd10; RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'd77;
        ReadReg1 = 5'd10; ReadReg2 = 5'd3;
        advance();
        settle();
        check("mix_busy10", DATA_W'(Busy1), 32'h1);
        check("mix_busy3", DATA_W'(Busy2), 32'h0);
        check("mix_pend", DATA_W'(PendingCount), 32'h1);
        advance();
        idle_inputs();
        RegWrite = 1'b1; WriteReg = 5'd10; WriteData = 32'h55;
        advance();
        idle_inputs();
        settle();
        check("waw_cleared", DATA_W'(Busy1), 32'h0);
        check("waw_pend", DATA_W'(PendingCount), 32'h0);
        advance();

        // Write to a non-busy register leaves it non-busy.
        RegWrite = 1'b1; WriteReg = 5'd12; WriteData = 32'hA5A5; ReadReg1 = 5'd12;
        advance();
        idle_inputs();
        settle();
        check("nb_rd1", ReadData1, 32'hA5A5);
        check("nb_busy1", DATA_W'(Busy1), 32'h0);
        advance();

        // Pattern sweep exercising interleaved issue/write traffic against the model.
        for (int i = 0; i < 40; i++) begin
            Issue     = (i % 3) != 2;
            IssueReg  = ADDR_W'((i * 7 + 1) % NUM_REGS);
            RegWrite  = (i % 4) != 0;
            WriteReg  = ADDR_W'((i * 5 + 3) % NUM_REGS);
            WriteData = 32'h1000_0000 + DATA_W'(i * 32'h0101_0101);
            ReadReg1  = ADDR_W'((i * 5 + 3) % NUM_REGS);
            ReadReg2  = ADDR_W'((i * 7 + 22) % NUM_REGS);
            RegFile_Address = ADDR_W'(i % NUM_REGS);
            advance();
        end
        idle_inputs();

        // Issue 1,2,3 back to back, then reset together with an issue to 4.
        for (int i = 1; i <= 3; i++) begin
            Issue = 1'b1; IssueReg = ADDR_W'(i);
            advance();
        end
        reset = 1'b1; Issue = 1'b1; IssueReg = 5'd4;
        RegWrite = 1'b1; WriteReg = 5'd6; WriteData = 32'hFFFF;
        advance();
        reset = 1'b0;
        idle_inputs();
        settle();
        check("post_rst_pend", DATA_W'(PendingCount), 32'h0);
        for (int i = 1; i <= 6; i++) begin
            ReadReg1 = ADDR_W'(i); ReadReg2 = ADDR_W'(i + 6);
            settle();
            check("post_rst_busy", DATA_W'({Busy1, Busy2}), 32'h0);
            check("post_rst_rd1", ReadData1, 32'h0);
            advance();
        end

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
